// File: rtl/board_register_writer_if.sv
// Board-state write-side bus: move requests in, board registers and strobes out.
interface board_register_writer_if #(
  parameter int COLS = 7,
  parameter int ROWS = 6
);
  logic                   drop;
  logic [2:0]             column;
  logic                   clear_board;
  logic                   game_over;
  logic                   player;
  logic [COLS*ROWS-1:0]   player_register;
  logic [COLS*ROWS-1:0]   onoff_register;
  logic [2:0]             location;
  logic [2:0]             height;
  logic                   move_done;
  logic                   invalid_move;
  logic                   board_full;

  modport master (
    output drop, column, clear_board, game_over,
    input  player, player_register, onoff_register, location, height,
           move_done, invalid_move, board_full
  );

  modport slave (
    input  drop, column, clear_board, game_over,
    output player, player_register, onoff_register, location, height,
           move_done, invalid_move, board_full
  );
endinterface

// File: rtl/board_register_writer.sv
// Owns the onoff/player board registers: drops a piece into a column, tracks
// column heights and turn, and strobes move_done / invalid_move to the win logic.
module board_register_writer #(
  parameter int COLS         = 7,
  parameter int ROWS         = 6,
  parameter bit FIRST_PLAYER = 1'b0
) (
  input  logic                  clk,
  input  logic                  resetn,
  board_register_writer_if.slave bus
);
  localparam int CELLS = COLS * ROWS;

  typedef enum logic [1:0] {IDLE, CHECK, WRITE, DONE} state_t;

  state_t                 state_q, state_d;
  logic [2:0]             col_q;
  logic [COLS-1:0][2:0]   colh_q;
  logic [5:0]             movecnt_q;
  logic                   player_q;
  logic [CELLS-1:0]       onoff_q, preg_q;
  logic [2:0]             loc_q, hgt_q;
  logic                   inv_q, inv_d;
  logic                   full_q;

  logic [2:0]             cur_h;
  logic                   col_ok;
  logic [5:0]             idx;
  logic                   accept;

  // Column lookup by search so an out-of-range col_q never indexes colh_q.
  always_comb begin
    cur_h  = '0;
    col_ok = 1'b0;
    for (int c = 0; c < COLS; c++) begin
      if (col_q == 3'(c)) begin
        cur_h  = colh_q[c];
        col_ok = 1'b1;
      end
    end
    idx = 6'(ROWS) * 6'(col_q) + 6'(cur_h);
  end

  assign accept = bus.drop && !bus.game_over;

  always_comb begin
    state_d = state_q;
    inv_d   = 1'b0;
    case (state_q)
      IDLE:  if (accept) state_d = CHECK;
      CHECK: begin
        if (!col_ok || cur_h == 3'(ROWS)) begin
          inv_d   = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = WRITE;
        end
      end
      WRITE:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      col_q     <= '0;
      colh_q    <= '0;
      movecnt_q <= '0;
      player_q  <= FIRST_PLAYER;
      onoff_q   <= '0;
      preg_q    <= '0;
      loc_q     <= '0;
      hgt_q     <= '0;
      inv_q     <= 1'b0;
      full_q    <= 1'b0;
    end else if (bus.clear_board) begin
      state_q   <= IDLE;
      col_q     <= '0;
      colh_q    <= '0;
      movecnt_q <= '0;
      player_q  <= FIRST_PLAYER;
      onoff_q   <= '0;
      preg_q    <= '0;
      loc_q     <= '0;
      hgt_q     <= '0;
      inv_q     <= 1'b0;
      full_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      inv_q   <= inv_d;
      if (state_q == IDLE && accept) col_q <= bus.column;
      // WRITE is only reached with a valid column that still has room.
      if (state_q == WRITE) begin
        onoff_q[idx] <= 1'b1;
        preg_q[idx]  <= player_q;
        loc_q        <= col_q;
        hgt_q        <= cur_h;
        movecnt_q    <= movecnt_q + 6'd1;
        for (int c = 0; c < COLS; c++) begin
          if (col_q == 3'(c)) colh_q[c] <= cur_h + 3'd1;
        end
      end
      if (state_q == DONE) begin
        player_q <= ~player_q;
        full_q   <= (movecnt_q == 6'(CELLS));
      end
    end
  end

  assign bus.player          = player_q;
  assign bus.player_register = preg_q;
  assign bus.onoff_register  = onoff_q;
  assign bus.location        = loc_q;
  assign bus.height          = hgt_q;
  assign bus.move_done       = (state_q == DONE);
  assign bus.invalid_move    = inv_q;
  assign bus.board_full      = full_q;
endmodule

// File: tb/tb_board_register_writer.sv
// Directed bench for board_register_writer with a small board model for expectations.
module tb_board_register_writer;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [41:0] exp_onoff, exp_preg;
  logic        exp_player;
  int          mh[7];
  int          cnt;

  board_register_writer_if bif();

  board_register_writer dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bif)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_onoff  = '0;
    exp_preg   = '0;
    exp_player = 1'b0;
    cnt        = 0;
    for (int c = 0; c < 7; c++) mh[c] = 0;
  endtask

  task automatic do_clear();
    bif.clear_board = 1'b1;
    step(1);
    bif.clear_board = 1'b0;
    model_reset();
    chk("clr_onoff", bif.onoff_register, 0);
    chk("clr_player", bif.player, 0);
  endtask

  // One drop request with exact cycle timing; expectations from the board model.
  task automatic do_drop(input logic [2:0] col, input string tag);
    bit ok;
    int idx;
    ok = 0;
    if (col < 7) ok = (mh[col] < 6);
    bif.drop = 1'b1; bif.column = col;
    step(1);
    bif.drop = 1'b0;
    step(1);
    if (!ok) begin
      chk({tag, "_inv"}, bif.invalid_move, 1);
      chk({tag, "_nodone"}, bif.move_done, 0);
      step(1);
      chk({tag, "_inv_pulse"}, bif.invalid_move, 0);
      chk({tag, "_onoff_kept"}, bif.onoff_register, exp_onoff);
      chk({tag, "_preg_kept"}, bif.player_register, exp_preg);
      chk({tag, "_player_kept"}, bif.player, exp_player);
    end else begin
      chk({tag, "_noinv"}, bif.invalid_move, 0);
      step(1);
      idx = 6 * col + mh[col];
      exp_onoff[idx] = 1'b1;
      exp_preg[idx]  = exp_player;
      chk({tag, "_done"}, bif.move_done, 1);
      chk({tag, "_loc"}, bif.location, col);
      chk({tag, "_hgt"}, bif.height, mh[col]);
      chk({tag, "_onoff"}, bif.onoff_register, exp_onoff);
      chk({tag, "_preg"}, bif.player_register, exp_preg);
      mh[col]++;
      cnt++;
      step(1);
      exp_player = ~exp_player;
      chk({tag, "_done_pulse"}, bif.move_done, 0);
      chk({tag, "_player"}, bif.player, exp_player);
      chk({tag, "_full"}, bif.board_full, (cnt == 42));
    end
  endtask

  initial begin
    int moves;
    int hexp;
    bif.drop = 1'b0; bif.column = '0; bif.clear_board = 1'b0; bif.game_over = 1'b0;
    model_reset();

    // reset state
    step(2);
    chk("rst_onoff", bif.onoff_register, 0);
    chk("rst_preg", bif.player_register, 0);
    chk("rst_player", bif.player, 0);
    chk("rst_loc", bif.location, 0);
    chk("rst_done", bif.move_done, 0);
    chk("rst_full", bif.board_full, 0);
    resetn = 1'b1;
    step(1);

    // first move into column 3 -> cell 18
    do_drop(3'd3, "c3");
    chk("c3_onoff_hand", bif.onoff_register, 42'h000_0004_0000);
    chk("c3_player_hand", bif.player, 1);

    // seven drops into column 0; last one overflows
    do_clear();
    for (int i = 0; i < 7; i++) do_drop(3'd0, $sformatf("c0_%0d", i));
    chk("c0_onoff_hand", bif.onoff_register, 42'h3F);
    chk("c0_preg_hand", bif.player_register, 42'h2A);
    chk("c0_player_hand", bif.player, 0);

    // out-of-range column
    do_drop(3'd7, "col7");

    // game_over blocks the request entirely
    bif.game_over = 1'b1; bif.drop = 1'b1; bif.column = 3'd1;
    for (int i = 0; i < 5; i++) begin
      step(1);
      if (i == 1) bif.drop = 1'b0;
      chk($sformatf("go_done_%0d", i), bif.move_done, 0);
      chk($sformatf("go_inv_%0d", i), bif.invalid_move, 0);
    end
    chk("go_onoff", bif.onoff_register, exp_onoff);
    bif.game_over = 1'b0;
    do_drop(3'd1, "after_go");

    // fill the whole board
    do_clear();
    for (int c = 0; c < 7; c++)
      for (int r = 0; r < 6; r++) do_drop(3'(c), $sformatf("fill_%0d_%0d", c, r));
    chk("fill_onoff", bif.onoff_register, {42{1'b1}});
    chk("fill_full", bif.board_full, 1);
    do_drop(3'd4, "full_drop");

    // clear during WRITE discards the move
    do_clear();
    do_drop(3'd6, "pre_clr");
    bif.drop = 1'b1; bif.column = 3'd1;
    step(1);
    bif.drop = 1'b0;
    step(1);
    bif.clear_board = 1'b1;
    step(1);
    bif.clear_board = 1'b0;
    model_reset();
    chk("wclr_onoff", bif.onoff_register, 0);
    chk("wclr_preg", bif.player_register, 0);
    chk("wclr_player", bif.player, 0);
    chk("wclr_loc", bif.location, 0);
    chk("wclr_done", bif.move_done, 0);
    step(1);
    chk("wclr_done2", bif.move_done, 0);
    chk("wclr_inv", bif.invalid_move, 0);

    // asynchronous reset in the middle of DONE
    bif.drop = 1'b1; bif.column = 3'd5;
    step(1);
    bif.drop = 1'b0;
    step(2);
    chk("ar_done_before", bif.move_done, 1);
    #2 resetn = 1'b0;
    #1;
    chk("ar_done", bif.move_done, 0);
    chk("ar_onoff", bif.onoff_register, 0);
    chk("ar_loc", bif.location, 0);
    chk("ar_hgt", bif.height, 0);
    chk("ar_player", bif.player, 0);
    #2 resetn = 1'b1;
    model_reset();
    step(1);

    // drop held for 12 cycles: one move every 4 cycles
    moves = 0;
    bif.drop = 1'b1; bif.column = 3'd2;
    for (int i = 1; i <= 12; i++) begin
      step(1);
      chk($sformatf("hold_done_%0d", i), bif.move_done, (i % 4 == 3));
      if (bif.move_done) begin
        hexp = i / 4;
        chk($sformatf("hold_hgt_%0d", i), bif.height, hexp);
        moves++;
      end
    end
    bif.drop = 1'b0;
    step(4);
    chk("hold_moves", moves, 3);
    chk("hold_onoff", bif.onoff_register, 42'h7000);
    chk("hold_preg", bif.player_register, 42'h2000);
    chk("hold_player", bif.player, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
